// File: rtl/alu_pkg.sv
// Shared op codes, widths and sequencer state encoding for the ALU sequencer.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DONE_W = 16;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_MUL  = 4'd4,
    OP_DIV  = 4'd5,
    OP_XOR  = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_SLT  = 4'd10,
    OP_SLTU = 4'd11,
    OP_NOT  = 4'd12
  } op_t;

  localparam logic [OP_W-1:0] OP_LAST = OP_NOT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Codes above OP_LAST are accepted but flagged as errors.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/settle_counter.sv
// 4-bit settle counter: load, decrement toward zero, zero flag.
module settle_counter
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Issues one op at a time to an external combinational ALU, waits the op's
// settle time, then holds the captured result until the consumer takes it.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned ADD_WAIT = 1,
  parameter int unsigned MUL_WAIT = 4,
  parameter int unsigned DIV_WAIT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [OP_W-1:0]     req_op,
  input  logic [DATA_W-1:0]   req_a,
  input  logic [DATA_W-1:0]   req_b,
  output logic [OP_W-1:0]     alu_op,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_hi,
  output logic [DATA_W-1:0]   resp_lo,
  output logic                resp_err,
  output logic                busy,
  output logic [DONE_W-1:0]   ops_done
);

  state_t           state;
  logic             err_flag;
  logic             cnt_zero_c;
  logic             load_c;
  logic             dec_c;
  logic [CNT_W-1:0] wait_sel_c;

  // Counter is loaded with W-1 so the capture lands exactly W edges after accept.
  always_comb begin
    wait_sel_c = CNT_W'(ADD_WAIT - 1);
    if (req_op == OP_MUL) begin
      wait_sel_c = CNT_W'(MUL_WAIT - 1);
    end else if (req_op == OP_DIV) begin
      wait_sel_c = CNT_W'(DIV_WAIT - 1);
    end
  end

  assign load_c = (state == ST_IDLE) && req_valid;
  assign dec_c  = (state == ST_WAIT) && !cnt_zero_c;

  settle_counter u_settle_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (load_c),
    .load_value (wait_sel_c),
    .dec        (dec_c),
    .zero_c     (cnt_zero_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      err_flag   <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      resp_hi    <= '0;
      resp_lo    <= '0;
      resp_err   <= 1'b0;
      resp_valid <= 1'b0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      ops_done   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            alu_op    <= op_legal(req_op) ? req_op : OP_AND;
            alu_a     <= req_a;
            alu_b     <= req_b;
            err_flag  <= !op_legal(req_op);
            state     <= ST_WAIT;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt_zero_c) begin
            resp_hi    <= alu_result[2*DATA_W-1:DATA_W];
            resp_lo    <= alu_result[DATA_W-1:0];
            resp_err   <= err_flag;
            resp_valid <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            ops_done   <= ops_done + DONE_W'(1);
            state      <= ST_IDLE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU and reference model.
module tb_alu_sequencer;

  localparam int unsigned ADD_W = 1;
  localparam int unsigned MUL_W = 4;
  localparam int unsigned DIV_W = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [63:0] alu_result;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_hi;
  logic [31:0] resp_lo;
  logic        resp_err;
  logic        busy;
  logic [15:0] ops_done;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [15:0] exp_done = '0;

  alu_sequencer #(
    .ADD_WAIT (ADD_W),
    .MUL_WAIT (MUL_W),
    .DIV_WAIT (DIV_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_hi    (resp_hi),
    .resp_lo    (resp_lo),
    .resp_err   (resp_err),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  always #5 clk = ~clk;

  // Behavioural ALU sitting outside the sequencer.
  function automatic logic [63:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      4'd0:  return {32'd0, a & b};
      4'd1:  return {32'd0, a | b};
      4'd2:  return {32'd0, a} + {32'd0, b};
      4'd3:  return {32'd0, a - b};
      4'd4:  return sa * sb;
      4'd5:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      4'd6:  return {32'd0, a ^ b};
      4'd7:  return {32'd0, a << b[4:0]};
      4'd8:  return {32'd0, a >> b[4:0]};
      4'd9:  return {32'd0, 32'($signed(a) >>> b[4:0])};
      4'd10: return {63'd0, $signed(a) < $signed(b)};
      4'd11: return {63'd0, a < b};
      4'd12: return {32'd0, ~a};
      default: return 64'd0;
    endcase
  endfunction

  always_comb alu_result = alu_f(alu_op, alu_a, alu_b);

  // Reference model: what the sequencer should present for a given request.
  function automatic int unsigned wait_of(input logic [3:0] op);
    if (op == 4'd4) return MUL_W;
    if (op == 4'd5) return DIV_W;
    return ADD_W;
  endfunction

  function automatic logic [3:0] eff_op(input logic [3:0] op);
    return (op > 4'd12) ? 4'd0 : op;
  endfunction

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    total_cnt++; if (req_ready !== 1'b1) $display("FAIL send_ready_timeout: got %b want 1", req_ready); else pass_cnt++;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_done = '0;
    total_cnt++; if ({req_ready, resp_valid, busy, resp_err} !== 4'b1000) $display("FAIL reset_flags: got %b want 1000", {req_ready, resp_valid, busy, resp_err}); else pass_cnt++;
    total_cnt++; if ({alu_op, alu_a, alu_b} !== 68'd0) $display("FAIL reset_alu: got %h want 0", {alu_op, alu_a, alu_b}); else pass_cnt++;
    total_cnt++; if ({resp_hi, resp_lo} !== 64'd0) $display("FAIL reset_resp: got %h want 0", {resp_hi, resp_lo}); else pass_cnt++;
    total_cnt++; if (ops_done !== 16'd0) $display("FAIL reset_ops_done: got %h want 0", ops_done); else pass_cnt++;
  endtask

  task automatic test_add();
    int lat;
    resp_ready = 1'b1;
    send(4'd2, 32'd5, 32'd7);
    total_cnt++; if ({alu_op, alu_a, alu_b} !== {4'd2, 32'd5, 32'd7}) $display("FAIL add_alu_drive: got %h want %h", {alu_op, alu_a, alu_b}, {4'd2, 32'd5, 32'd7}); else pass_cnt++;
    wait_resp(lat);
    total_cnt++; if (lat != 1) $display("FAIL add_latency: got %0d want 1", lat); else pass_cnt++;
    total_cnt++; if ({resp_hi, resp_lo, resp_err} !== {32'd0, 32'd12, 1'b0}) $display("FAIL add_resp: got %h_%h err %b want 0_c err 0", resp_hi, resp_lo, resp_err); else pass_cnt++;
    @(posedge clk); #1;
    exp_done++;
    total_cnt++; if (ops_done !== exp_done) $display("FAIL add_ops_done: got %h want %h", ops_done, exp_done); else pass_cnt++;
    total_cnt++; if ({req_ready, resp_valid, busy} !== 3'b100) $display("FAIL add_back_idle: got %b want 100", {req_ready, resp_valid, busy}); else pass_cnt++;
  endtask

  task automatic test_mul();
    int lat;
    resp_ready = 1'b1;
    send(4'd4, 32'hFFFF_FFFD, 32'd5);
    wait_resp(lat);
    total_cnt++; if (lat != MUL_W) $display("FAIL mul_latency: got %0d want %0d", lat, MUL_W); else pass_cnt++;
    total_cnt++; if ({resp_hi, resp_lo} !== 64'hFFFF_FFFF_FFFF_FFF1) $display("FAIL mul_resp: got %h_%h want ffffffff_fffffff1", resp_hi, resp_lo); else pass_cnt++;
    @(posedge clk); #1;
    exp_done++;
    total_cnt++; if (ops_done !== exp_done) $display("FAIL mul_ops_done: got %h want %h", ops_done, exp_done); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int lat;
    resp_ready = 1'b0;
    send(4'd3, 32'd10, 32'd3);
    wait_resp(lat);
    total_cnt++; if (lat != ADD_W) $display("FAIL bp_latency: got %0d want %0d", lat, ADD_W); else pass_cnt++;
    req_valid = 1'b1; req_op = 4'd2; req_a = 32'd1; req_b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total_cnt++; if ({resp_valid, req_ready} !== 2'b10) $display("FAIL bp_hold_flags: cycle %0d got %b want 10", i, {resp_valid, req_ready}); else pass_cnt++;
      total_cnt++; if ({resp_hi, resp_lo} !== 64'd7) $display("FAIL bp_hold_resp: cycle %0d got %h want 7", i, {resp_hi, resp_lo}); else pass_cnt++;
      total_cnt++; if ({alu_op, alu_a} !== {4'd3, 32'd10}) $display("FAIL bp_ignore_req: cycle %0d got %h want 3_a", i, {alu_op, alu_a}); else pass_cnt++;
      total_cnt++; if (ops_done !== exp_done) $display("FAIL bp_no_count: cycle %0d got %h want %h", i, ops_done, exp_done); else pass_cnt++;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    exp_done++;
    total_cnt++; if (ops_done !== exp_done) $display("FAIL bp_release_count: got %h want %h", ops_done, exp_done); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (ops_done !== exp_done) $display("FAIL bp_count_once: got %h want %h", ops_done, exp_done); else pass_cnt++;
    total_cnt++; if ({resp_lo, req_ready, resp_valid} !== {32'd7, 2'b10}) $display("FAIL bp_retain: got %h want 7_2", {resp_lo, req_ready, resp_valid}); else pass_cnt++;
  endtask

  task automatic test_illegal();
    int lat;
    logic [31:0] a, b;
    a = 32'hF0F0_1234; b = 32'h0FF0_FFFF;
    resp_ready = 1'b0;
    send(4'd14, a, b);
    total_cnt++; if ({alu_op, alu_a} !== {4'd0, a}) $display("FAIL ill_alu_op: got %h want %h", {alu_op, alu_a}, {4'd0, a}); else pass_cnt++;
    wait_resp(lat);
    total_cnt++; if (lat != ADD_W) $display("FAIL ill_latency: got %0d want %0d", lat, ADD_W); else pass_cnt++;
    total_cnt++; if (resp_err !== 1'b1) $display("FAIL ill_err: got %b want 1", resp_err); else pass_cnt++;
    total_cnt++; if ({resp_hi, resp_lo} !== alu_f(4'd0, a, b)) $display("FAIL ill_resp: got %h want %h", {resp_hi, resp_lo}, alu_f(4'd0, a, b)); else pass_cnt++;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    exp_done++;
    send(4'd2, 32'd3, 32'd4);
    wait_resp(lat);
    total_cnt++; if ({resp_err, resp_lo} !== {1'b0, 32'd7}) $display("FAIL ill_next_err: got %h want 0_7", {resp_err, resp_lo}); else pass_cnt++;
    @(posedge clk); #1;
    exp_done++;
    total_cnt++; if (ops_done !== exp_done) $display("FAIL ill_ops_done: got %h want %h", ops_done, exp_done); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int last = -1;
    int accepts = 0;
    int cyc = 0;
    resp_ready = 1'b1;
    req_valid = 1'b1; req_op = 4'd2; req_a = $urandom; req_b = $urandom;
    while (accepts < 4 && cyc < 60) begin
      if (req_ready) begin
        if (last >= 0) begin
          total_cnt++; if (cyc - last != ADD_W + 2) $display("FAIL b2b_spacing: got %0d want %0d", cyc - last, ADD_W + 2); else pass_cnt++;
        end
        last = cyc;
        accepts++;
      end
      @(posedge clk); #1; cyc++;
    end
    req_valid = 1'b0;
    total_cnt++; if (accepts != 4) $display("FAIL b2b_accepts: got %0d want 4", accepts); else pass_cnt++;
    repeat (ADD_W + 3) begin
      @(posedge clk); #1;
    end
    exp_done += 16'd4;
    total_cnt++; if (ops_done !== exp_done) $display("FAIL b2b_ops_done: got %h want %h", ops_done, exp_done); else pass_cnt++;
  endtask

  task automatic test_random();
    int lat;
    int stall;
    logic [3:0] op;
    logic [31:0] a, b;
    logic [63:0] exp_res;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      stall = $urandom_range(0, 3);
      exp_res = alu_f(eff_op(op), a, b);
      resp_ready = 1'b0;
      send(op, a, b);
      total_cnt++; if ({alu_op, alu_a, alu_b} !== {eff_op(op), a, b}) $display("FAIL rnd_alu_drive: iter %0d got %h want %h", i, {alu_op, alu_a, alu_b}, {eff_op(op), a, b}); else pass_cnt++;
      wait_resp(lat);
      total_cnt++; if (lat != wait_of(op)) $display("FAIL rnd_latency: iter %0d op %0d got %0d want %0d", i, op, lat, wait_of(op)); else pass_cnt++;
      repeat (stall) begin
        @(posedge clk); #1;
      end
      total_cnt++; if (resp_valid !== 1'b1) $display("FAIL rnd_valid_held: iter %0d got %b want 1", i, resp_valid); else pass_cnt++;
      total_cnt++; if ({resp_hi, resp_lo} !== exp_res) $display("FAIL rnd_resp: iter %0d op %0d got %h want %h", i, op, {resp_hi, resp_lo}, exp_res); else pass_cnt++;
      total_cnt++; if (resp_err !== (op > 4'd12)) $display("FAIL rnd_err: iter %0d op %0d got %b want %b", i, op, resp_err, op > 4'd12); else pass_cnt++;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      exp_done++;
      total_cnt++; if (ops_done !== exp_done) $display("FAIL rnd_ops_done: iter %0d got %h want %h", i, ops_done, exp_done); else pass_cnt++;
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_midwait();
    int lat;
    int seen = 0;
    resp_ready = 1'b1;
    send(4'd5, 32'd100, 32'd7);
    repeat (2) begin
      @(posedge clk); #1;
    end
    total_cnt++; if ({busy, resp_valid} !== 2'b10) $display("FAIL rw_in_wait: got %b want 10", {busy, resp_valid}); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_done = '0;
    total_cnt++; if ({req_ready, resp_valid, busy, resp_err} !== 4'b1000) $display("FAIL rw_flags: got %b want 1000", {req_ready, resp_valid, busy, resp_err}); else pass_cnt++;
    total_cnt++; if ({alu_op, alu_a, alu_b} !== 68'd0) $display("FAIL rw_alu: got %h want 0", {alu_op, alu_a, alu_b}); else pass_cnt++;
    total_cnt++; if ({resp_hi, resp_lo} !== 64'd0) $display("FAIL rw_resp: got %h want 0", {resp_hi, resp_lo}); else pass_cnt++;
    total_cnt++; if (ops_done !== 16'd0) $display("FAIL rw_ops_done: got %h want 0", ops_done); else pass_cnt++;
    repeat (DIV_W + 2) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    total_cnt++; if (seen != 0) $display("FAIL rw_discarded: got %0d responses want 0", seen); else pass_cnt++;
    // Reset while a response is being taken must not count it.
    send(4'd2, 32'd1, 32'd2);
    wait_resp(lat);
    total_cnt++; if (lat != ADD_W) $display("FAIL rd_latency: got %0d want %0d", lat, ADD_W); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if ({ops_done, resp_valid, req_ready} !== {16'd0, 2'b01}) $display("FAIL rd_priority: got %h want 1", {ops_done, resp_valid, req_ready}); else pass_cnt++;
    req_valid = 1'b1; req_op = 4'd6; req_a = 32'hDEAD_BEEF; req_b = 32'h1;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    total_cnt++; if ({alu_op, alu_a, busy} !== 37'd0) $display("FAIL ri_no_accept: got %h want 0", {alu_op, alu_a, busy}); else pass_cnt++;
  endtask

  task automatic test_wrap();
    int lat;
    force dut.ops_done = 16'hFFFF;
    @(posedge clk); #1;
    release dut.ops_done;
    exp_done = 16'hFFFF;
    @(posedge clk); #1;
    total_cnt++; if (ops_done !== exp_done) $display("FAIL wrap_preload: got %h want %h", ops_done, exp_done); else pass_cnt++;
    resp_ready = 1'b1;
    send(4'd0, 32'hFF, 32'h0F);
    wait_resp(lat);
    @(posedge clk); #1;
    exp_done++;
    total_cnt++; if (ops_done !== 16'h0000 || ops_done !== exp_done) $display("FAIL wrap_rollover: got %h want 0000", ops_done); else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_midwait();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter ADD_WAIT, default 1: settle cycles for ops 0-3 and 6-12.
REQ-002 SHALL have parameter MUL_WAIT, default 4: settle cycles for op 4.
REQ-003 SHALL have parameter DIV_WAIT, default 8: settle cycles for op 5; all WAIT parameters in range 1..15.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  sequencer can accept a request.
REQ-008 req_op  in  4  ALU op code (0 AND ... 12 NOT; 13-15 illegal).
REQ-009 req_a, req_b  in  32 each  operands.
REQ-010 alu_op  out  4  op code driven to the ALU.
REQ-011 alu_a, alu_b  out  32 each  operands driven to the ALU.
REQ-012 alu_result  in  64  combinational ALU result.
REQ-013 resp_valid  out  1  response held.
REQ-014 resp_ready  in  1  consumer takes the response.
REQ-015 resp_hi, resp_lo  out  32 each  captured alu_result[63:32] and [31:0].
REQ-016 resp_err  out  1  request carried an illegal op.
REQ-017 busy  out  1  high whenever state is not IDLE.
REQ-018 ops_done  out  16  count of completed responses.

Function
REQ-019 States SHALL be IDLE, WAIT, DONE; req_ready = (state==IDLE).
REQ-020 Accept SHALL occur on an edge where req_valid && req_ready: alu_op/alu_a/alu_b registered from req_*, counter loaded with (selected WAIT − 1), state -> WAIT.
REQ-021 Illegal op (13-15) SHALL be accepted, alu_op driven 0, err flag registered 1; legal ops register err flag 0.
REQ-022 alu_op/alu_a/alu_b SHALL remain stable from accept until the next accept.
REQ-023 In WAIT, counter != 0 SHALL decrement; counter == 0 SHALL capture alu_result into resp_hi/resp_lo, drive resp_err from flag, state -> DONE.
REQ-024 Latency SHALL be exactly W cycles from accept edge to first cycle of resp_valid (W = selected WAIT).
REQ-025 resp_valid SHALL equal (state==DONE); resp_hi/lo/err SHALL hold while resp_valid && !resp_ready.
REQ-026 DONE with resp_ready SHALL go to IDLE and increment ops_done (wraps 0xFFFF -> 0x0000).
REQ-027 No request SHALL be accepted in the DONE->IDLE handoff cycle; minimum spacing between accepts is W+2 cycles.
REQ-028 req_valid while not IDLE SHALL be ignored with no state change.
REQ-029 resp_hi/lo SHALL retain the last response after leaving DONE until the next capture.

Reset
REQ-030 rst SHALL, at any state including mid-WAIT or DONE, force: state IDLE, counter 0, alu_op 0, alu_a 0, alu_b 0, resp_hi 0, resp_lo 0, resp_err 0, resp_valid 0, busy 0, ops_done 0, req_ready 1 on next cycle.
REQ-031 rst SHALL take priority over accept and over resp_ready in the same cycle; an in-flight op is discarded without counting.

Structure
REQ-032 Op code constants (OP_AND..OP_NOT, OP_LAST=12) and the state encoding SHALL live in a shared package alu_pkg.
REQ-033 The settle counter SHALL be one sub-module, settle_counter (load, decrement, zero flag, 4 bits).
REQ-034 The ALU SHALL NOT be instantiated inside; alu_* ports connect to it externally.

Verification
REQ-035 op 2, a=5, b=7, resp_ready=1 -> resp_valid 1 cycle after accept, resp_lo=12, resp_hi=0, ops_done=1.
REQ-036 op 4, a=-3, b=5 -> resp_valid exactly 4 cycles after accept, resp_hi=0xFFFFFFFF, resp_lo=0xFFFFFFF1.
REQ-037 op 3, a=10, b=3, resp_ready low 5 cycles -> resp_lo=7 held, req_ready=0, new req_valid ignored, ops_done increments once on release.
REQ-038 op 5 accepted, rst pulsed on 3rd WAIT cycle -> all outputs zero next cycle, req_ready=1, ops_done=0.
REQ-039 op 14 -> alu_op=0, resp_err=1; following op 2 -> resp_err=0.
REQ-040 preload 0xFFFF completions (force or loop), one more -> ops_done=0x0000.
